stack_mem_master: RTL
=====================

# stack_mem_master

Stack-access initiator that drives the single-port 32x8 word memory (WE/RE, 5-bit address, 8-bit write data, registered read data) on behalf of the stack datapath. It accepts PUSH/POP/PEEK/CLEAR commands over a valid/ready handshake and maintains the stack pointer. It turns each command into the memory's write or read-with-one-cycle-latency sequence and returns one response per command. It sits between the multi-cycle stack controller and the memory.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 8, data width
- STACK_BASE, 16, memory address of stack slot 0; requires STACK_BASE+DEPTH <= 2**ADDR_W
- DEPTH, 16, stack capacity in words
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_op  in  2  00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
- cmd_data  in  DATA_W  PUSH operand
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  DATA_W  popped/peeked/pushed value, 0 on error or CLEAR
- rsp_err  out  1  overflow/underflow, qualified by rsp_valid
- sp  out  clog2(DEPTH+1)  element count, 0..DEPTH
- empty, full  out  1 each  sp==0, sp==DEPTH
- mem_we, mem_re  out  1 each  memory write/read enables
- mem_addr  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data, valid the cycle after the edge that sampled mem_re

## Operation
- States: IDLE, WR, RD, CAP. Handshake fires on cmd_valid & cmd_ready at a posedge; op and data latched.
- PUSH, not full: IDLE->WR. WR drives mem_we=1, mem_addr=STACK_BASE+sp, mem_wd=latched data. At the end of WR: sp+1, rsp_data=data, rsp_err=0, rsp_valid=1; ->IDLE.
- POP/PEEK, not empty: IDLE->RD. RD drives mem_re=1, mem_addr=STACK_BASE+sp-1. RD->CAP. At the end of CAP: rsp_data=mem_rd, rsp_valid=1; POP also decrements sp; ->IDLE.
- Error (PUSH when full, POP/PEEK when empty): no memory access. At the accept edge: rsp_valid=1, rsp_err=1, rsp_data=0. sp unchanged; stays IDLE.
- CLEAR: at the accept edge: sp=0, rsp_valid=1, rsp_err=0, rsp_data=0. Memory is untouched.
- mem_we/mem_re are decoded from state only; never both high.
- Outside WR/RD, mem_addr=0 and mem_wd=0.
- Address arithmetic is done in ADDR_W bits; the parameter constraint guarantees no wrap.

## Timing
- Reset (asynchronous, immediate): state=IDLE, sp=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - mem_we=mem_re=0, mem_addr=0, mem_wd=0; empty=1, full=0; cmd_ready=1 once rst_n is high.
- Reset mid-operation aborts the command. A WR interrupted by reset must not write memory, since mem_we drops combinationally. No response is produced for the aborted command.
- Latency, accept edge = edge 0:
  - PUSH: rsp_valid high in cycle 2.
  - POP/PEEK: rsp_valid high in cycle 3.
  - Error/CLEAR: rsp_valid high in cycle 1.
- cmd_ready is high during the rsp_valid cycle, so back-to-back commands are allowed.
- Throughput: PUSH 1 command per 2 cycles; POP/PEEK 1 per 3 cycles.
- sp, empty and full update at the same edge that raises rsp_valid.

## Configuration
- STACK_TOS_CACHE_EN defined: adds a top-of-stack register plus tos_valid flag.
  - PUSH sets both; POP, CLEAR and reset clear tos_valid.
  - POP/PEEK with tos_valid=1 skip RD/CAP and use no memory access. rsp_valid is high in cycle 1 with the cached value; POP decrements sp.
  - With tos_valid=0, the memory path is used unchanged.
- Not defined: no cache; all POP/PEEK use the memory path.

## Test plan
- Reset: hold rst_n=0 -> sp=0, empty=1, full=0, rsp_valid=0, mem_we=mem_re=0, mem_addr=0.
- PUSH 0xA5 (STACK_BASE=16): cycle 1 mem_we=1, mem_addr=16, mem_wd=A5; cycle 2 rsp_valid=1, rsp_data=A5, sp=1.
- PUSH A5, PUSH 3C, POP, POP (macro off):
  - First POP: mem_re at addr 17, rsp_data=3C in cycle 3, sp=1.
  - Second POP: mem_re at addr 16, rsp_data=A5, sp=0, empty=1.
- POP on empty -> cycle 1 rsp_valid=1, rsp_err=1, rsp_data=0, mem_re never high. 16 PUSHes -> full=1; 17th PUSH -> rsp_err=1, no mem_we, sp=16; CLEAR -> sp=0.
- Pull rst_n low during a WR cycle -> mem_we falls immediately, sp=0, no rsp_valid; memory word at that address keeps its old value.
- STACK_TOS_CACHE_EN defined: PUSH 5A, PEEK -> rsp_valid cycle 1 with 5A and mem_re stays 0. POP -> 5A in cycle 1. A following POP of the older element uses RD/CAP (cycle 3).

Source files
------------

// File: rtl/stack_mem_master_if.sv
// rtl/stack_mem_master_if.sv - command, response and memory bus of the stack memory initiator
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_data   command handshake from the stack controller
//   rsp_valid/rsp_data/rsp_err            one-cycle response pulse, no backpressure
//   mem_we/mem_re/mem_addr/mem_wd/mem_rd  single-port word memory, registered read data
// Modports: master = stack_mem_master side, slave = controller/memory side.
interface stack_mem_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, mem_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output mem_we, mem_re, mem_addr, mem_wd
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, mem_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_we, mem_re, mem_addr, mem_wd
  );
endinterface

// File: rtl/stack_mem_master.sv
// rtl/stack_mem_master.sv - stack pointer keeper turning PUSH/POP/PEEK/CLEAR into memory accesses
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      command/response handshake and memory bus (see stack_mem_master_if)
//   sp                element count 0..DEPTH
//   empty, full       sp==0, sp==DEPTH
// Optional feature: STACK_TOS_CACHE_EN adds a top-of-stack register so POP/PEEK
// of the most recently pushed word answer without a memory read.
module stack_mem_master #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int STACK_BASE = 16,
  parameter int DEPTH      = 16,
  parameter int SP_W       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  stack_mem_master_if.master  bus,
  output logic [SP_W-1:0]     sp,
  output logic                empty,
  output logic                full
);

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(STACK_BASE);

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              fire;
  logic              is_push, is_read;
  logic              push_err, read_err, cache_hit;

  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));

  assign fire     = bus.cmd_valid & bus.cmd_ready;
  assign is_push  = (bus.cmd_op == OP_PUSH);
  assign is_read  = (bus.cmd_op == OP_POP) | (bus.cmd_op == OP_PEEK);
  assign push_err = is_push & full;
  assign read_err = is_read & empty;

`ifdef STACK_TOS_CACHE_EN
  logic [DATA_W-1:0] tos;
  logic              tos_valid;

  assign cache_hit = is_read & ~empty & tos_valid;

  // tos always mirrors the word at sp-1 while tos_valid is set; any pop
  // exposes an older word we do not hold, so the flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos       <= '0;
      tos_valid <= 1'b0;
    end else if (state == WR) begin
      tos       <= data_q;
      tos_valid <= 1'b1;
    end else if (fire && (bus.cmd_op == OP_CLEAR || (cache_hit && bus.cmd_op == OP_POP))) begin
      tos_valid <= 1'b0;
    end else if (state == CAP && op_q == OP_POP) begin
      tos_valid <= 1'b0;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; errors, CLEAR and cache hits complete at the accept edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fire) begin
          if (is_push && !push_err)                   state_nxt = WR;
          else if (is_read && !read_err && !cache_hit) state_nxt = RD;
        end
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops mem_we immediately
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.mem_we    = (state == WR);
    bus.mem_re    = (state == RD);
    bus.mem_addr  = '0;
    bus.mem_wd    = '0;
    if (state == WR) begin
      bus.mem_addr = BASE + ADDR_W'(sp);
      bus.mem_wd   = data_q;
    end else if (state == RD) begin
      bus.mem_addr = BASE + ADDR_W'(sp) - ADDR_W'(1);
    end
  end

  // Datapath: latched command, stack pointer, registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_PUSH;
      data_q        <= '0;
      sp            <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            op_q   <= bus.cmd_op;
            data_q <= bus.cmd_data;
            if (push_err || read_err) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
            end else if (bus.cmd_op == OP_CLEAR) begin
              sp            <= '0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_data  <= '0;
            end
`ifdef STACK_TOS_CACHE_EN
            else if (cache_hit) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_data  <= tos;
              if (bus.cmd_op == OP_POP) sp <= sp - SP_W'(1);
            end
`endif
          end
        end
        WR: begin
          sp            <= sp + SP_W'(1);
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= data_q;
        end
        CAP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= bus.mem_rd;
          if (op_q == OP_POP) sp <= sp - SP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
